// File: rtl/core_fetch_unit.sv
// core_fetch_unit: instruction fetch front end with a small prefetch FIFO.
// Keeps at most one instruction-memory request in flight, tags each response
// with its PC, and queues it for the decode stage. A redirect flushes the queue
// and restarts fetching at the word-aligned target. If a request is still in
// flight when the redirect arrives, its response is dropped.
// Optional feature: define CFU_PERF_COUNTERS_EN to add fetch/flush counters.
module core_fetch_unit #(
    parameter int                   DATAWIDTH  = 32,
    parameter logic [DATAWIDTH-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int                   DEPTH      = 4,
    parameter int                   INSMEMSTEP = 4
) (
    input  logic                         CFU_Clk_In,
    input  logic                         CFU_Reset_In,
    input  logic [DATAWIDTH-1:0]         CFU_Insmem_Readdata_InBUS,
    input  logic                         CFU_Insmem_Valid_In,
    output logic                         CFU_Insmem_Ready_Out,
    output logic [DATAWIDTH-1:0]         CFU_Insmem_Addr_OutBUS,
    input  logic                         CFU_Redirect_In,
    input  logic [DATAWIDTH-1:0]         CFU_Redirect_Addr_InBUS,
    output logic                         CFU_Ins_Valid_Out,
    output logic [DATAWIDTH-1:0]         CFU_Ins_OutBUS,
    output logic [DATAWIDTH-1:0]         CFU_Ins_Pc_OutBUS,
    input  logic                         CFU_Ins_Ready_In,
`ifdef CFU_PERF_COUNTERS_EN
    output logic [31:0]                  CFU_Perf_Fetch_OutBUS,
    output logic [31:0]                  CFU_Perf_Flush_OutBUS,
`endif
    output logic [$clog2(DEPTH):0]       CFU_Count_OutBUS
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATAWIDTH-1:0] ALIGN_MASK = {{(DATAWIDTH-2){1'b1}}, 2'b00};
    localparam logic [CW-1:0]        DEPTH_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } state_e;

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   pc_q, pc_d;
    logic [DATAWIDTH-1:0]   addr_q, addr_d;
    logic                   ready_q, ready_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATAWIDTH-1:0]   buf_data_q [DEPTH];
    logic [DATAWIDTH-1:0]   buf_pc_q   [DEPTH];

    logic                   head_valid;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count_after;

    // Next-state logic: a redirect overrides push/pop; otherwise advance the fetch FSM.
    always_comb begin
        head_valid  = (count_q != '0);
        push        = (state_q == ST_REQ) && CFU_Insmem_Valid_In && !CFU_Redirect_In;
        pop         = head_valid && CFU_Ins_Ready_In && !CFU_Redirect_In;
        count_after = count_q + CW'(push) - CW'(pop);

        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_after;

        if (CFU_Redirect_In) begin
            pc_d     = CFU_Redirect_Addr_InBUS & ALIGN_MASK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            case (state_q)
                ST_IDLE:    state_d = ST_REQ;
                ST_REQ,
                ST_DISCARD: state_d = CFU_Insmem_Valid_In ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_after < DEPTH_CNT) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (CFU_Insmem_Valid_In) begin
                        pc_d    = pc_q + DATAWIDTH'(INSMEMSTEP);
                        state_d = (count_after < DEPTH_CNT) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (CFU_Insmem_Valid_In) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        addr_d  = (state_d == ST_DISCARD) ? addr_q : pc_d;
        ready_d = (state_d != ST_IDLE);
    end

    // Control registers: FSM state, fetch PC, registered request outputs and FIFO pointers.
    always_ff @(posedge CFU_Clk_In or negedge CFU_Reset_In) begin
        if (!CFU_Reset_In) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_ADDR;
            addr_q   <= RESET_ADDR;
            ready_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Prefetch storage: each accepted response is written together with its fetch PC.
    always_ff @(posedge CFU_Clk_In or negedge CFU_Reset_In) begin
        if (!CFU_Reset_In) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else if (push) begin
            buf_data_q[wr_ptr_q] <= CFU_Insmem_Readdata_InBUS;
            buf_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

    // Head presentation: instruction and PC buses read as zero when the buffer is empty.
    always_comb begin
        CFU_Ins_Valid_Out      = head_valid;
        CFU_Ins_OutBUS         = head_valid ? buf_data_q[rd_ptr_q] : '0;
        CFU_Ins_Pc_OutBUS      = head_valid ? buf_pc_q[rd_ptr_q]   : '0;
        CFU_Insmem_Ready_Out   = ready_q;
        CFU_Insmem_Addr_OutBUS = addr_q;
        CFU_Count_OutBUS       = count_q;
    end

`ifdef CFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Performance counters: accepted responses and redirects, both wrap naturally.
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(push);
        perf_flush_d = perf_flush_q + 32'(CFU_Redirect_In);
    end

    // Performance counter registers.
    always_ff @(posedge CFU_Clk_In or negedge CFU_Reset_In) begin
        if (!CFU_Reset_In) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign CFU_Perf_Fetch_OutBUS = perf_fetch_q;
    assign CFU_Perf_Flush_OutBUS = perf_flush_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_core_fetch_unit.sv
// Testbench for core_fetch_unit (DEPTH=4, RESET_ADDR=0, step 4).
// Per-cycle vector table plus hand-built corner sequences and a streaming
// scoreboard. Define CFU_PERF_COUNTERS_EN to also check the perf counters.
module tb_core_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  count;
`ifdef CFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] raddr;
        logic        rdy;
        logic        e_ready;
        logic [31:0] e_addr;
        logic [2:0]  e_count;
        logic        e_ivalid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] sbq [$];

    core_fetch_unit #(
        .DATAWIDTH (32),
        .RESET_ADDR(32'h0000_0000),
        .DEPTH     (4),
        .INSMEMSTEP(4)
    ) dut (
        .CFU_Clk_In               (clk),
        .CFU_Reset_In             (rst_n),
        .CFU_Insmem_Readdata_InBUS(mem_rdata),
        .CFU_Insmem_Valid_In      (mem_valid),
        .CFU_Insmem_Ready_Out     (mem_ready),
        .CFU_Insmem_Addr_OutBUS   (mem_addr),
        .CFU_Redirect_In          (redirect),
        .CFU_Redirect_Addr_InBUS  (redirect_addr),
        .CFU_Ins_Valid_Out        (ins_valid),
        .CFU_Ins_OutBUS           (ins_data),
        .CFU_Ins_Pc_OutBUS        (ins_pc),
        .CFU_Ins_Ready_In         (ins_ready),
`ifdef CFU_PERF_COUNTERS_EN
        .CFU_Perf_Fetch_OutBUS    (perf_fetch),
        .CFU_Perf_Flush_OutBUS    (perf_flush),
`endif
        .CFU_Count_OutBUS         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word returned by the memory model for a given address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic rd,
                                 input logic [31:0] ra, input logic rdy, input logic er,
                                 input logic [31:0] ea, input logic [2:0] ec,
                                 input logic eiv, input logic [31:0] ep);
        vec_t t;
        t.valid = v;   t.rdata = d;   t.redir = rd;  t.raddr = ra;   t.rdy = rdy;
        t.e_ready = er; t.e_addr = ea; t.e_count = ec; t.e_ivalid = eiv; t.e_pc = ep;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mem_valid     = v.valid;
        mem_rdata     = v.rdata;
        redirect      = v.redir;
        redirect_addr = v.raddr;
        ins_ready     = v.rdy;
    endtask

    task automatic setIdle();
        mem_valid = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_addr = '0; ins_ready = 1'b0;
    endtask

    // One clock: drive the vector, step past the edge, compare every output.
    task automatic runVec(input vec_t v, input string tag);
        logic [31:0] exp_ins;
        applyStimulus(v);
        @(posedge clk);
        #1;
        exp_ins = v.e_ivalid ? memData(v.e_pc) : 32'h0;
        checkOutput({tag, ".ready"}, 32'(mem_ready), 32'(v.e_ready));
        checkOutput({tag, ".addr"},  mem_addr, v.e_addr);
        checkOutput({tag, ".count"}, 32'(count), 32'(v.e_count));
        checkOutput({tag, ".ivalid"}, 32'(ins_valid), 32'(v.e_ivalid));
        checkOutput({tag, ".pc"},    ins_pc, v.e_ivalid ? v.e_pc : 32'h0);
        checkOutput({tag, ".ins"},   ins_data, exp_ins);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ready"},  32'(mem_ready), 32'h0);
        checkOutput({tag, ".addr"},   mem_addr, 32'h0);
        checkOutput({tag, ".count"},  32'(count), 32'h0);
        checkOutput({tag, ".ivalid"}, 32'(ins_valid), 32'h0);
        checkOutput({tag, ".ins"},    ins_data, 32'h0);
        checkOutput({tag, ".pc"},     ins_pc, 32'h0);
`ifdef CFU_PERF_COUNTERS_EN
        checkOutput({tag, ".perf_fetch"}, perf_fetch, 32'h0);
        checkOutput({tag, ".perf_flush"}, perf_flush, 32'h0);
`endif
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        setIdle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pops;
        logic [31:0] exp_fetch;
        logic [31:0] exp_pc;

        // Fill until full with no consumer, then drain/refill around the full mark.
        tbl[0] = mkv(0, 32'h0,             0, 0, 0, 1, 32'h00, 0, 0, 32'h0);
        tbl[1] = mkv(1, memData(32'h00),   0, 0, 0, 1, 32'h04, 1, 1, 32'h0);
        tbl[2] = mkv(1, memData(32'h04),   0, 0, 0, 1, 32'h08, 2, 1, 32'h0);
        tbl[3] = mkv(1, memData(32'h08),   0, 0, 0, 1, 32'h0C, 3, 1, 32'h0);
        tbl[4] = mkv(1, memData(32'h0C),   0, 0, 0, 0, 32'h10, 4, 1, 32'h0);
        tbl[5] = mkv(1, 32'hDEAD_BEEF,     0, 0, 0, 0, 32'h10, 4, 1, 32'h0);
        tbl[6] = mkv(0, 32'h0,             0, 0, 1, 1, 32'h10, 3, 1, 32'h4);
        tbl[7] = mkv(1, memData(32'h10),   0, 0, 1, 1, 32'h14, 3, 1, 32'h8);
        tbl[8] = mkv(1, memData(32'h14),   0, 0, 0, 0, 32'h18, 4, 1, 32'h8);
        tbl[9] = mkv(0, 32'h0,             0, 0, 1, 1, 32'h18, 3, 1, 32'hC);

        rst_n = 1'b0;
        setIdle();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("pre_edge.ready", 32'(mem_ready), 32'h0);

        for (int i = 0; i < 10; i++) begin
            runVec(tbl[i], $sformatf("fill%0d", i));
        end

        // Redirect while the request to 0x8 is pending; its late response is dropped.
        doReset();
        runVec(mkv(0, 32'h0,           0, 32'h0,   0, 1, 32'h000, 0, 0, 32'h0),   "rd.a");
        runVec(mkv(1, memData(32'h0),  0, 32'h0,   0, 1, 32'h004, 1, 1, 32'h0),   "rd.b");
        runVec(mkv(1, memData(32'h4),  0, 32'h0,   0, 1, 32'h008, 2, 1, 32'h0),   "rd.c");
        runVec(mkv(0, 32'h0,           1, 32'h103, 0, 1, 32'h008, 0, 0, 32'h0),   "rd.d");
        runVec(mkv(0, 32'h0,           0, 32'h0,   1, 1, 32'h008, 0, 0, 32'h0),   "rd.e");
        runVec(mkv(0, 32'h0,           0, 32'h0,   0, 1, 32'h008, 0, 0, 32'h0),   "rd.f");
        runVec(mkv(1, 32'hDEAD_BEEF,   0, 32'h0,   0, 1, 32'h100, 0, 0, 32'h0),   "rd.g");
        runVec(mkv(1, memData(32'h100),0, 32'h0,   0, 1, 32'h104, 1, 1, 32'h100), "rd.h");

        // Full buffer, redirect with consumer ready; then redirect coincident with a response.
        doReset();
        runVec(mkv(0, 32'h0,            0, 32'h0,   0, 1, 32'h000, 0, 0, 32'h0),   "fl.a");
        runVec(mkv(1, memData(32'h0),   0, 32'h0,   0, 1, 32'h004, 1, 1, 32'h0),   "fl.b");
        runVec(mkv(1, memData(32'h4),   0, 32'h0,   0, 1, 32'h008, 2, 1, 32'h0),   "fl.c");
        runVec(mkv(1, memData(32'h8),   0, 32'h0,   0, 1, 32'h00C, 3, 1, 32'h0),   "fl.d");
        runVec(mkv(1, memData(32'hC),   0, 32'h0,   0, 0, 32'h010, 4, 1, 32'h0),   "fl.e");
        runVec(mkv(0, 32'h0,            1, 32'h200, 1, 1, 32'h200, 0, 0, 32'h0),   "fl.f");
        runVec(mkv(1, memData(32'h200), 0, 32'h0,   0, 1, 32'h204, 1, 1, 32'h200), "fl.g");
        runVec(mkv(1, 32'hDEAD_BEEF,    1, 32'h302, 0, 1, 32'h300, 0, 0, 32'h0),   "fl.h");
        runVec(mkv(1, memData(32'h300), 0, 32'h0,   0, 1, 32'h304, 1, 1, 32'h300), "fl.i");

        // Streaming: zero-wait memory, consumer always ready, scoreboard of fetched PCs.
        doReset();
        pops      = 0;
        exp_fetch = 32'h0;
        sbq.delete();
        for (int cyc = 0; cyc < 24; cyc++) begin
            ins_ready = 1'b1;
            redirect  = 1'b0;
            mem_valid = mem_ready;
            mem_rdata = memData(mem_addr);
            if (mem_ready) begin
                checkOutput("stream.fetch_addr", mem_addr, exp_fetch);
                sbq.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'h4;
            end
            if (cyc >= 2) begin
                checkOutput("stream.no_gap", 32'(ins_valid), 32'h1);
            end
            if (ins_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("stream.sb_underflow", 32'(sbq.size()), 32'h1);
                end else begin
                    exp_pc = sbq.pop_front();
                    checkOutput("stream.head_pc",  ins_pc, exp_pc);
                    checkOutput("stream.head_ins", ins_data, memData(exp_pc));
                    pops++;
                end
            end
            @(posedge clk);
            #1;
        end
        checkOutput("stream.pops", 32'(pops), 32'd22);
        checkOutput("stream.sb_left", 32'(sbq.size()), 32'd1);
`ifdef CFU_PERF_COUNTERS_EN
        checkOutput("stream.perf_fetch", perf_fetch, 32'd23);
        checkOutput("stream.perf_flush", perf_flush, 32'd0);
`endif

        // Reset asserted with a request outstanding; a late response after release is ignored.
        doReset();
        runVec(mkv(0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0), "rst.a");
        rst_n = 1'b0;
        #2;
        checkResetState("rst.mid");
        @(posedge clk);
        #1;
        checkResetState("rst.held");
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        rst_n     = 1'b1;
        runVec(mkv(1, 32'hDEAD_BEEF,  0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0), "rst.b");
        runVec(mkv(1, memData(32'h0), 0, 32'h0, 0, 1, 32'h4, 1, 1, 32'h0), "rst.c");

        setIdle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
